// File: rtl/bram_rw_controller_pkg.sv
// Shared constants for the BRAM write/readback sequencer.
// This package defines the FSM state encoding and the default data, address and memory sizes.
package bram_rw_controller_pkg;

    localparam int DEF_DWIDTH   = 16;
    localparam int DEF_AWIDTH   = 7;
    localparam int DEF_MEM_SIZE = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bram_rw_controller_true_dpbram.sv
// Single-clock true dual-port block RAM with a registered read on each port.
// The memory array is never reset; the two read registers reset to zero.
module true_dpbram
    import bram_rw_controller_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] i_addr0,
    input  logic              i_ce0,
    input  logic              i_we0,
    input  logic [DWIDTH-1:0] i_d0,
    output logic [DWIDTH-1:0] o_q0,
    input  logic [AWIDTH-1:0] i_addr1,
    input  logic              i_ce1,
    input  logic              i_we1,
    input  logic [DWIDTH-1:0] i_d1,
    output logic [DWIDTH-1:0] o_q1
);

    logic [DWIDTH-1:0] r_mem [MEM_SIZE];
    logic [DWIDTH-1:0] r_q0;
    logic [DWIDTH-1:0] r_q1;

    // Port 0 is written last, so it wins when both ports write the same address.
    always_ff @(posedge clk) begin
        if (i_ce1 && i_we1) r_mem[i_addr1] <= i_d1;
        if (i_ce0 && i_we0) r_mem[i_addr0] <= i_d0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (i_ce0 && !i_we0) r_q0 <= r_mem[i_addr0];
            if (i_ce1 && !i_we1) r_q1 <= r_mem[i_addr1];
        end
    end

    assign o_q0 = r_q0;
    assign o_q1 = r_q1;

endmodule

// File: rtl/bram_rw_controller.sv
// Sequencer that writes N words to an embedded BRAM through port 0 and then streams them back.
// Port 1 of the BRAM is passed straight through so that another agent can use it.
module bram_rw_controller
    import bram_rw_controller_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int AWIDTH   = DEF_AWIDTH,
    parameter int MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_read,
    output logic              o_done,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_mem_data,
    input  logic [AWIDTH-1:0] addr1,
    input  logic              ce1,
    input  logic              we1,
    input  logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] q1
);

    logic [1:0]        r_state;
    logic [AWIDTH-1:0] r_cnt;
    logic [AWIDTH-1:0] r_num;
    logic              r_valid;

    logic              w_ce0;
    logic              w_we0;
    logic [AWIDTH-1:0] w_addr0;
    logic [DWIDTH-1:0] w_d0;
    logic [DWIDTH-1:0] w_q0;
    logic              w_last;

    assign w_last = (r_cnt == r_num - AWIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_num   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_ce0 & ~w_we0;
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_num   <= i_num_cnt;
                        r_cnt   <= '0;
                        r_state <= (i_num_cnt == '0) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_READ;
                    end else begin
                        r_cnt <= r_cnt + AWIDTH'(1);
                    end
                end
                ST_READ: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + AWIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Port 0 is only driven during the two transfer phases; each written word is its own address.
    always_comb begin
        w_ce0   = 1'b0;
        w_we0   = 1'b0;
        w_addr0 = '0;
        w_d0    = '0;
        if (r_state == ST_WRITE) begin
            w_ce0   = 1'b1;
            w_we0   = 1'b1;
            w_addr0 = r_cnt;
            w_d0    = DWIDTH'(r_cnt);
        end else if (r_state == ST_READ) begin
            w_ce0   = 1'b1;
            w_addr0 = r_cnt;
        end
    end

    true_dpbram #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .MEM_SIZE (MEM_SIZE)
    ) u_bram (
        .clk     (clk),
        .reset   (reset),
        .i_addr0 (w_addr0),
        .i_ce0   (w_ce0),
        .i_we0   (w_we0),
        .i_d0    (w_d0),
        .o_q0    (w_q0),
        .i_addr1 (addr1),
        .i_ce1   (ce1),
        .i_we1   (we1),
        .i_d1    (d1),
        .o_q1    (q1)
    );

    assign o_idle     = (r_state == ST_IDLE);
    assign o_write    = (r_state == ST_WRITE);
    assign o_read     = (r_state == ST_READ);
    assign o_done     = (r_state == ST_DONE);
    assign o_valid    = r_valid;
    assign o_mem_data = r_valid ? w_q0 : '0;

endmodule

// File: tb/tb_bram_rw_controller.sv
// Directed testbench for bram_rw_controller: write/readback passes, zero-length run, interrupts and port 1.
// Expected phase flags and readback words come from the cycle offsets relative to the start edge.
module tb_bram_rw_controller;

    logic        clk;
    logic        reset;
    logic        i_run;
    logic [6:0]  i_num_cnt;
    logic        o_idle;
    logic        o_write;
    logic        o_read;
    logic        o_done;
    logic        o_valid;
    logic [15:0] o_mem_data;
    logic [6:0]  addr1;
    logic        ce1;
    logic        we1;
    logic [15:0] d1;
    logic [15:0] q1;

    int checks = 0;
    int errors = 0;

    bram_rw_controller dut (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_num_cnt  (i_num_cnt),
        .o_idle     (o_idle),
        .o_write    (o_write),
        .o_read     (o_read),
        .o_done     (o_done),
        .o_valid    (o_valid),
        .o_mem_data (o_mem_data),
        .addr1      (addr1),
        .ce1        (ce1),
        .we1        (we1),
        .d1         (d1),
        .q1         (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " idle"},  32'(o_idle),     32'd1);
        checkOutput({tag, " write"}, 32'(o_write),    32'd0);
        checkOutput({tag, " read"},  32'(o_read),     32'd0);
        checkOutput({tag, " done"},  32'(o_done),     32'd0);
        checkOutput({tag, " valid"}, 32'(o_valid),    32'd0);
        checkOutput({tag, " data"},  32'(o_mem_data), 32'd0);
    endtask

    // Starts a pass of n words from an IDLE cycle and checks every cycle until IDLE returns.
    // With interfere set, a second start pulse and a different count are driven during the write phase.
    task automatic applyStimulus(input int n, input bit interfere);
        bit expWrite, expRead, expDone, expIdle, expValid;
        int expData;
        i_run     = 1'b1;
        i_num_cnt = 7'(n);
        for (int k = 1; k <= 2 * n + 2; k++) begin
            stepCycle();
            i_run = 1'b0;
            expWrite = (k >= 1) && (k <= n);
            expRead  = (k >= n + 1) && (k <= 2 * n);
            expDone  = (k == 2 * n + 1);
            expIdle  = (k == 2 * n + 2);
            expValid = (k >= n + 2) && (k <= 2 * n + 1);
            expData  = expValid ? (k - n - 2) : 0;
            checkOutput($sformatf("n%0d k%0d write", n, k), 32'(o_write),    32'(expWrite));
            checkOutput($sformatf("n%0d k%0d read",  n, k), 32'(o_read),     32'(expRead));
            checkOutput($sformatf("n%0d k%0d done",  n, k), 32'(o_done),     32'(expDone));
            checkOutput($sformatf("n%0d k%0d idle",  n, k), 32'(o_idle),     32'(expIdle));
            checkOutput($sformatf("n%0d k%0d valid", n, k), 32'(o_valid),    32'(expValid));
            checkOutput($sformatf("n%0d k%0d data",  n, k), 32'(o_mem_data), 32'(expData));
            if (interfere && k == 3) begin
                i_run     = 1'b1;
                i_num_cnt = 7'd5;
            end
        end
        i_run = 1'b0;
    endtask

    initial begin
        $display("[TB] starting bram_rw_controller bench");
        reset     = 1'b1;
        i_run     = 1'b0;
        i_num_cnt = '0;
        addr1     = '0;
        ce1       = 1'b0;
        we1       = 1'b0;
        d1        = '0;

        stepCycle();
        stepCycle();
        checkIdleOutputs("reset");
        reset = 1'b0;
        stepCycle();
        checkIdleOutputs("post reset");

        applyStimulus(100, 1'b0);
        applyStimulus(1, 1'b0);
        applyStimulus(0, 1'b0);
        stepCycle();
        checkIdleOutputs("n0 settle");

        applyStimulus(127, 1'b0);
        applyStimulus(5, 1'b0);
        applyStimulus(8, 1'b1);

        // A reset during the write phase must return to IDLE with no completion pulse.
        i_run     = 1'b1;
        i_num_cnt = 7'd10;
        stepCycle();
        i_run = 1'b0;
        checkOutput("midwrite started", 32'(o_write), 32'd1);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkIdleOutputs("midwrite reset");
        stepCycle();
        checkIdleOutputs("midwrite after");
        stepCycle();
        checkIdleOutputs("midwrite after2");

        ce1   = 1'b1;
        we1   = 1'b0;
        addr1 = 7'd3;
        stepCycle();
        checkOutput("port1 read addr3", 32'(q1), 32'd3);
        addr1 = 7'd120;
        stepCycle();
        checkOutput("port1 read addr120", 32'(q1), 32'd120);

        we1   = 1'b1;
        addr1 = 7'd50;
        d1    = 16'hBEEF;
        stepCycle();
        checkOutput("port1 write hold q1", 32'(q1), 32'd120);
        we1 = 1'b0;
        stepCycle();
        checkOutput("port1 readback", 32'(q1), 32'hBEEF);
        ce1 = 1'b0;
        addr1 = 7'd4;
        stepCycle();
        checkOutput("port1 q1 holds", 32'(q1), 32'hBEEF);

        // The port-1 write above must be overwritten by a new pass through port 0.
        applyStimulus(60, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
